tx_jesd_sync_ctrl: RTL and testbench



---
 rtl/jesd204b_pkg.sv | 15 +
 rtl/tx_jesd_sync_ctrl_if.sv | 23 ++
 rtl/tx_lmfc_cnt.sv | 24 ++
 rtl/tx_jesd_sync_ctrl.sv | 172 +++++++++++++++++
 tb/tb_tx_jesd_sync_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jesd204b_pkg.sv
// Shared JESD204B TX definitions: control characters and link-state encoding.
package jesd204b_pkg;

   localparam logic [7:0] K28_5 = 8'hBC;  // /K/ code-group sync
   localparam logic [7:0] K28_0 = 8'h1C;  // /R/ multiframe start
   localparam logic [7:0] K28_3 = 8'h7C;  // /A/ multiframe end
   localparam logic [7:0] K28_4 = 8'h9C;  // /Q/ config follows

   typedef enum logic [1:0] {
      ST_CGS  = 2'd0,
      ST_ILAS = 2'd1,
      ST_DATA = 2'd2
   } link_state_t;

endpackage

// File: rtl/tx_jesd_sync_ctrl_if.sv
// Octet path between user source, the sync controller and the TX link layer.
interface tx_jesd_sync_ctrl_if;

   // s_data is consumed on every clock where s_vld && s_rdy; s_rdy never
   // depends on s_vld. o_data/o_k are meaningful only while o_vld is high.
   logic [7:0] s_data;
   logic       s_vld;
   logic       s_rdy;
   logic [7:0] o_data;
   logic       o_vld;
   logic       o_k;

   modport master (
      output s_data, s_vld,
      input  s_rdy, o_data, o_vld, o_k
   );

   modport slave (
      input  s_data, s_vld,
      output s_rdy, o_data, o_vld, o_k
   );

endinterface

// File: rtl/tx_lmfc_cnt.sv
// Free-running local multiframe counter 0..FK-1 with a registered wrap pulse.
module tx_lmfc_cnt #(
   parameter int FK = 32,
   parameter int CW = $clog2(FK)
) (
   input  logic          clk,
   input  logic          rst,
   output logic [CW-1:0] cnt,
   output logic          o_lmfc
);

   localparam logic [CW-1:0] LAST = CW'(FK - 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         o_lmfc <= 1'b0;
      end else begin
         o_lmfc <= (cnt == '0);
         cnt    <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/tx_jesd_sync_ctrl.sv
// JESD204B TX link-state controller: CGS -> LMFC-aligned ILAS -> user data.
// Define TX_STATUS_CNT_EN to add underflow and resync event counters.
module tx_jesd_sync_ctrl
   import jesd204b_pkg::*;
#(
   parameter int F          = 1,
   parameter int K          = 32,
   parameter int ILAS_MF    = 4,
   parameter int RESYNC_CYC = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sync_n,
   input  logic [111:0]         ilas_cfg,
   tx_jesd_sync_ctrl_if.slave   link,
   output logic [1:0]           o_state,
   output logic                 o_lmfc,
   output logic                 o_underflow
`ifdef TX_STATUS_CNT_EN
   ,
   output logic [15:0]          o_underflow_cnt,
   output logic [7:0]           o_resync_cnt
`endif
);

   localparam int FK  = F * K;
   localparam int CW  = $clog2(FK);
   localparam int MFW = (ILAS_MF > 1) ? $clog2(ILAS_MF) : 1;
   localparam int RCW = $clog2(RESYNC_CYC + 1);
   localparam logic [CW-1:0] LAST = CW'(FK - 1);

   if (F * K < 17) begin : g_fk_check
      $error("tx_jesd_sync_ctrl: F*K must be at least 17");
   end

   logic [CW-1:0]  cnt;
   link_state_t    state, state_nxt;
   logic [MFW-1:0] mf, mf_nxt;
   logic [RCW-1:0] low_cnt, low_cnt_nxt;
   logic [111:0]   cfg_q;
   logic           wrap;
   logic           resync_hit;
   logic           entering_cgs;
   logic [3:0]     cfg_idx;
   logic [7:0]     ilas_data;
   logic           ilas_k;

   tx_lmfc_cnt #(.FK(FK), .CW(CW)) u_lmfc (
      .clk    (clk),
      .rst    (rst),
      .cnt    (cnt),
      .o_lmfc (o_lmfc)
   );

   assign wrap         = (cnt == LAST);
   assign entering_cgs = (state != ST_CGS) && (state_nxt == ST_CGS);
   assign link.s_rdy   = (state == ST_DATA);
   assign o_state      = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_CGS;
         mf      <= '0;
         low_cnt <= '0;
      end else begin
         state   <= state_nxt;
         mf      <= mf_nxt;
         low_cnt <= low_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      mf_nxt      = mf;
      low_cnt_nxt = '0;
      resync_hit  = 1'b0;
      // Short sync_n low runs are receiver error reports; only a sustained run resyncs.
      if (state != ST_CGS && !sync_n) begin
         if (low_cnt == RCW'(RESYNC_CYC - 1)) resync_hit = 1'b1;
         else                                 low_cnt_nxt = low_cnt + RCW'(1);
      end
      case (state)
         ST_CGS: begin
            if (sync_n && wrap) begin
               state_nxt = ST_ILAS;
               mf_nxt    = '0;
            end
         end
         ST_ILAS: begin
            if (wrap) begin
               if (mf == MFW'(ILAS_MF - 1)) state_nxt = ST_DATA;
               else                         mf_nxt    = mf + MFW'(1);
            end
         end
         ST_DATA: state_nxt = ST_DATA;
         default: state_nxt = ST_CGS;
      endcase
      if (resync_hit) state_nxt = ST_CGS;
   end

   // ILAS octet for the current multiframe position; the config block fills mf 1.
   assign cfg_idx = cnt[3:0] - 4'd2;

   always_comb begin
      ilas_data = 8'(cnt);
      ilas_k    = 1'b0;
      if (cnt == '0) begin
         ilas_data = K28_0;
         ilas_k    = 1'b1;
      end else if (wrap) begin
         ilas_data = K28_3;
         ilas_k    = 1'b1;
      end else if (mf == MFW'(1) && cnt == CW'(1)) begin
         ilas_data = K28_4;
         ilas_k    = 1'b1;
      end else if (mf == MFW'(1) && cnt <= CW'(15)) begin
         ilas_data = cfg_q[{cfg_idx, 3'b000} +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         link.o_data <= 8'h00;
         link.o_vld  <= 1'b0;
         link.o_k    <= 1'b0;
         o_underflow <= 1'b0;
         cfg_q       <= '0;
      end else begin
         if (state == ST_CGS && state_nxt == ST_ILAS) cfg_q <= ilas_cfg;
         case (state)
            ST_CGS: begin
               link.o_data <= K28_5;
               link.o_k    <= 1'b1;
               link.o_vld  <= 1'b1;
            end
            ST_ILAS: begin
               link.o_data <= ilas_data;
               link.o_k    <= ilas_k;
               link.o_vld  <= 1'b1;
            end
            ST_DATA: begin
               link.o_k   <= 1'b0;
               link.o_vld <= link.s_vld;
               if (link.s_vld) link.o_data <= link.s_data;
            end
            default: begin
               link.o_k   <= 1'b0;
               link.o_vld <= 1'b0;
            end
         endcase
         if (entering_cgs)                          o_underflow <= 1'b0;
         else if (state == ST_DATA && !link.s_vld)  o_underflow <= 1'b1;
      end
   end

`ifdef TX_STATUS_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         o_underflow_cnt <= '0;
         o_resync_cnt    <= '0;
      end else begin
         if (entering_cgs)
            o_underflow_cnt <= '0;
         else if (state == ST_DATA && !link.s_vld && o_underflow_cnt != 16'hFFFF)
            o_underflow_cnt <= o_underflow_cnt + 16'd1;
         if (resync_hit && o_resync_cnt != 8'hFF)
            o_resync_cnt <= o_resync_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tx_jesd_sync_ctrl.sv
// Self-checking bench for tx_jesd_sync_ctrl: directed sequences, a DATA-phase vector table, random traffic.
module tb_tx_jesd_sync_ctrl;
   import jesd204b_pkg::*;

   localparam int FK          = 32;
   localparam int ILAS_OCTETS = 4 * FK;
   localparam int RESYNC      = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         sync_n;
   logic [111:0] ilas_cfg;
   logic [1:0]   o_state;
   logic         o_lmfc;
   logic         o_underflow;

   tx_jesd_sync_ctrl_if link();

   tx_jesd_sync_ctrl #(.F(1), .K(32), .ILAS_MF(4), .RESYNC_CYC(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .sync_n      (sync_n),
      .ilas_cfg    (ilas_cfg),
      .link        (link),
      .o_state     (o_state),
      .o_lmfc      (o_lmfc),
      .o_underflow (o_underflow)
   );

   always #4 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference model: link mode, absolute multiframe position, ILAS octet index.
   int         m_mode, m_pos, m_n, m_low;
   logic [7:0] m_cfg [14];
   logic [7:0] e_data;
   logic       e_vld, e_k, e_lmfc, e_uf;

   task automatic ilas_oct(input int n, output logic [7:0] d, output logic k);
      int mfi, p;
      mfi = n / FK;
      p   = n % FK;
      if (p == 0)                            begin d = 8'h1C; k = 1'b1; end
      else if (p == FK - 1)                  begin d = 8'h7C; k = 1'b1; end
      else if (mfi == 1 && p == 1)           begin d = 8'h9C; k = 1'b1; end
      else if (mfi == 1 && p >= 2 && p <= 15) begin d = m_cfg[p-2]; k = 1'b0; end
      else                                   begin d = 8'(p); k = 1'b0; end
   endtask

   task automatic model_edge();
      int nxt;
      if (rst) begin
         m_mode = 0; m_pos = 0; m_n = 0; m_low = 0;
         e_data = 8'h00; e_vld = 0; e_k = 0; e_lmfc = 0; e_uf = 0;
         return;
      end
      e_lmfc = (m_pos == 0);
      case (m_mode)
         0: begin e_data = 8'hBC; e_k = 1'b1; e_vld = 1'b1; end
         1: begin ilas_oct(m_n, e_data, e_k); e_vld = 1'b1; end
         default: begin
            if (link.s_vld) begin e_data = link.s_data; e_k = 1'b0; e_vld = 1'b1; end
            else begin e_vld = 1'b0; e_k = 1'b0; e_uf = 1'b1; end
         end
      endcase
      nxt = m_mode;
      if (m_mode == 0) begin
         m_low = 0;
         if (sync_n && m_pos == FK - 1) begin
            nxt = 1;
            m_n = 0;
            for (int i = 0; i < 14; i++) m_cfg[i] = ilas_cfg[8*i +: 8];
         end
      end else begin
         if (m_mode == 1) begin
            m_n++;
            if (m_n == ILAS_OCTETS) nxt = 2;
         end
         m_low = sync_n ? 0 : m_low + 1;
         if (m_low == RESYNC) begin
            nxt = 0; m_low = 0; e_uf = 1'b0;
         end
      end
      m_pos  = (m_pos + 1) % FK;
      m_mode = nxt;
   endtask

   task automatic model_check();
      chk("o_data", link.o_data, e_data);
      chk("o_vld", link.o_vld, e_vld);
      chk("o_k", link.o_k, e_k);
      chk("o_lmfc", o_lmfc, e_lmfc);
      chk("o_underflow", o_underflow, e_uf);
      chk("o_state", o_state, m_mode);
      chk("s_rdy", link.s_rdy, (m_mode == 2));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      model_check();
   endtask

   typedef struct {
      logic       sn;
      logic       vld;
      logic [7:0] data;
      logic       e_vld;
      logic [7:0] e_data;
      logic       e_k;
      logic       e_uf;
      logic [1:0] e_state;
      logic       e_rdy;
   } vec_t;

   function automatic vec_t mk(logic sn, logic vld, logic [7:0] d, logic ev, logic [7:0] ed,
                               logic ek, logic eu, logic [1:0] es, logic er);
      vec_t v;
      v.sn = sn; v.vld = vld; v.data = d; v.e_vld = ev; v.e_data = ed;
      v.e_k = ek; v.e_uf = eu; v.e_state = es; v.e_rdy = er;
      return v;
   endfunction

   vec_t       tbl [14];
   logic [7:0] exp_q [$];
   logic [7:0] q_d [$];
   logic       q_k [$];

   initial begin
      int steps, steps_to_1c, ilas_cyc, last_pulse, pulses, burst;
      logic started;

      tbl[0]  = mk(1, 1, 8'hA5, 1, 8'hA5, 0, 0, 2'd2, 1);
      tbl[1]  = mk(1, 0, 8'h00, 0, 8'hA5, 0, 1, 2'd2, 1);
      tbl[2]  = mk(1, 1, 8'hA5, 1, 8'hA5, 0, 1, 2'd2, 1);
      tbl[3]  = mk(1, 1, 8'h3C, 1, 8'h3C, 0, 1, 2'd2, 1);
      tbl[4]  = mk(0, 1, 8'h11, 1, 8'h11, 0, 1, 2'd2, 1);
      tbl[5]  = mk(0, 1, 8'h22, 1, 8'h22, 0, 1, 2'd2, 1);
      tbl[6]  = mk(0, 1, 8'h33, 1, 8'h33, 0, 1, 2'd2, 1);
      tbl[7]  = mk(1, 1, 8'h44, 1, 8'h44, 0, 1, 2'd2, 1);
      tbl[8]  = mk(0, 1, 8'h55, 1, 8'h55, 0, 1, 2'd2, 1);
      tbl[9]  = mk(0, 0, 8'h66, 0, 8'h55, 0, 1, 2'd2, 1);
      tbl[10] = mk(0, 1, 8'h77, 1, 8'h77, 0, 1, 2'd2, 1);
      tbl[11] = mk(0, 1, 8'h88, 1, 8'h88, 0, 0, 2'd0, 0);
      tbl[12] = mk(0, 1, 8'h99, 1, 8'hBC, 1, 0, 2'd0, 0);
      tbl[13] = mk(0, 0, 8'h00, 1, 8'hBC, 1, 0, 2'd0, 0);

      rst = 1'b1; sync_n = 1'b0; link.s_vld = 1'b0; link.s_data = 8'h00;
      for (int i = 0; i < 14; i++) ilas_cfg[8*i +: 8] = 8'(i + 1);

      // Reset values
      step(); step();
      chk("rst_o_data", link.o_data, 8'h00);
      chk("rst_o_vld", link.o_vld, 1'b0);
      chk("rst_o_k", link.o_k, 1'b0);
      chk("rst_o_state", o_state, 2'd0);
      chk("rst_s_rdy", link.s_rdy, 1'b0);
      chk("rst_o_lmfc", o_lmfc, 1'b0);
      chk("rst_o_underflow", o_underflow, 1'b0);
      rst = 1'b0;

      // CGS with sync_n held low; LMFC pulse spacing
      last_pulse = -1; pulses = 0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (o_lmfc) begin
            if (last_pulse >= 0) chk("lmfc_period", cyc - last_pulse, FK);
            last_pulse = cyc;
            pulses++;
         end
      end
      chk("lmfc_pulses", pulses, 7);
      chk("cgs_state", o_state, 2'd0);

      // sync_n rises mid-multiframe; then the full ILAS
      steps = 0;
      while (m_pos != 10 && steps < 64) begin step(); steps++; end
      chk("align_wait", m_pos, 10);
      sync_n = 1'b1;
      step();
      steps = 0; steps_to_1c = -1; ilas_cyc = 0; started = 1'b0;
      while (steps < 400) begin
         step();
         steps++;
         if (o_state == 2'd1) ilas_cyc++;
         if (!started && link.o_vld && link.o_k && link.o_data == 8'h1C) begin
            started = 1'b1;
            steps_to_1c = steps;
         end
         if (started) begin q_d.push_back(link.o_data); q_k.push_back(link.o_k); end
         if (o_state == 2'd2) break;
      end
      chk("ilas_done", o_state, 2'd2);
      chk("first_1c_delay", steps_to_1c, 22);
      chk("ilas_cycles", ilas_cyc, ILAS_OCTETS);
      chk("ilas_octets", q_d.size(), ILAS_OCTETS);
      if (q_d.size() == ILAS_OCTETS) begin
         chk("ilas_q", {q_k[FK+1], q_d[FK+1]}, 9'h19C);
         for (int p = 2; p <= 15; p++) exp_q.push_back(8'(p - 1));
         for (int p = 2; p <= 15; p++) chk("ilas_cfg", q_d[FK+p], exp_q.pop_front());
         for (int m = 0; m < 4; m++) begin
            chk("ilas_r", {q_k[m*FK], q_d[m*FK]}, 9'h11C);
            chk("ilas_a", {q_k[m*FK+FK-1], q_d[m*FK+FK-1]}, 9'h17C);
         end
      end

      // DATA-phase vectors: pass-through, underflow, short and long sync_n lows
      for (int i = 0; i < 14; i++) begin
         sync_n = tbl[i].sn; link.s_vld = tbl[i].vld; link.s_data = tbl[i].data;
         step();
         chk("tbl_o_vld", link.o_vld, tbl[i].e_vld);
         chk("tbl_o_data", link.o_data, tbl[i].e_data);
         chk("tbl_o_k", link.o_k, tbl[i].e_k);
         chk("tbl_o_underflow", o_underflow, tbl[i].e_uf);
         chk("tbl_o_state", o_state, tbl[i].e_state);
         chk("tbl_s_rdy", link.s_rdy, tbl[i].e_rdy);
      end

      // Reset in the middle of ILAS multiframe 2
      sync_n = 1'b1; link.s_vld = 1'b0;
      steps = 0;
      while (!(m_mode == 1 && m_n == 2*FK + 5) && steps < 300) begin step(); steps++; end
      chk("reach_mf2", m_n, 2*FK + 5);
      rst = 1'b1;
      step();
      chk("mrst_o_data", link.o_data, 8'h00);
      chk("mrst_o_vld", link.o_vld, 1'b0);
      chk("mrst_o_k", link.o_k, 1'b0);
      chk("mrst_o_state", o_state, 2'd0);
      chk("mrst_s_rdy", link.s_rdy, 1'b0);
      chk("mrst_o_lmfc", o_lmfc, 1'b0);
      chk("mrst_o_underflow", o_underflow, 1'b0);
      rst = 1'b0; sync_n = 1'b0;
      step();
      chk("mrst_lmfc_restart", o_lmfc, 1'b1);
      chk("mrst_cgs_octet", {link.o_k, link.o_data}, 9'h1BC);
      pulses = 0;
      for (int i = 0; i < FK - 1; i++) begin step(); if (o_lmfc) pulses++; end
      chk("mrst_no_early_lmfc", pulses, 0);
      step();
      chk("mrst_lmfc_period", o_lmfc, 1'b1);

      // Randomised traffic against the model
      burst = 0;
      sync_n = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 1499) == 0);
         if (burst > 0) begin
            sync_n = 1'b0; burst--;
         end else begin
            sync_n = 1'b1;
            if ($urandom_range(0, 29) == 0)
               burst = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 40) : $urandom_range(1, 3);
         end
         link.s_vld  = ($urandom_range(0, 3) != 0);
         link.s_data = 8'($urandom);
         if ($urandom_range(0, 99) == 0)
            for (int j = 0; j < 14; j++) ilas_cfg[8*j +: 8] = 8'($urandom);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
